// File: rtl/jelly2_axi4s_pattern_generator.sv
// AXI4-Stream video test-pattern source: programmable geometry and blanking,
// ramp/checker/solid patterns, tuser at frame start and tlast at line end.
module jelly2_axi4s_pattern_generator #(
  parameter int COMPONENTS  = 1,
  parameter int DATA_WIDTH  = 10,
  parameter int X_WIDTH     = 16,
  parameter int Y_WIDTH     = 16,
  parameter int F_WIDTH     = 16,
  parameter int TDATA_WIDTH = COMPONENTS * DATA_WIDTH
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,
  input  logic                   enable,
  output logic                   busy,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,
  input  logic [X_WIDTH-1:0]     param_x_blank,
  input  logic [Y_WIDTH-1:0]     param_y_blank,
  input  logic [1:0]             param_mode,
  input  logic [TDATA_WIDTH-1:0] param_fill,
  output logic                   m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic [X_WIDTH-1:0]     m_axi4s_tx,
  output logic [Y_WIDTH-1:0]     m_axi4s_ty,
  output logic [F_WIDTH-1:0]     m_axi4s_tf,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready
);

  localparam int XC = X_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_VBLANK} state_t;

  state_t                 state_q, state_d;
  logic [XC-1:0]          x_q, x_d;
  logic [Y_WIDTH-1:0]     y_q, y_d;
  logic [F_WIDTH-1:0]     f_q, f_d;
  logic [X_WIDTH-1:0]     width_q, width_d, xblank_q, xblank_d;
  logic [Y_WIDTH-1:0]     height_q, height_d, yblank_q, yblank_d;
  logic [1:0]             mode_q, mode_d;
  logic [TDATA_WIDTH-1:0] fill_q, fill_d;
  logic                   valid_q, valid_d, user_q, user_d, last_q, last_d, busy_q, busy_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [X_WIDTH-1:0]     tx_q, tx_d;
  logic [Y_WIDTH-1:0]     ty_q, ty_d;

  logic                   start_ok, load, line_end, restart, latch;
  logic [X_WIDTH-1:0]     bx, bwidth;
  logic [Y_WIDTH-1:0]     by;
  logic [F_WIDTH-1:0]     bf;
  logic [1:0]             bmode;
  logic [TDATA_WIDTH-1:0] bfill;
  logic [XC-1:0]          width_last, xblank_last, period_last;
  logic [Y_WIDTH-1:0]     height_last, yblank_last;

  function automatic logic [TDATA_WIDTH-1:0] pattern(
    input logic [1:0]             mode,
    input logic [TDATA_WIDTH-1:0] fill,
    input logic [X_WIDTH-1:0]     x,
    input logic [Y_WIDTH-1:0]     y,
    input logic [F_WIDTH-1:0]     f
  );
    logic [TDATA_WIDTH-1:0] d;
    d = '0;
    for (int unsigned c = 0; c < COMPONENTS; c++) begin
      case (mode)
        2'd1:    d[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{x[3] ^ y[3]}};
        2'd2:    d[c*DATA_WIDTH +: DATA_WIDTH] = fill[c*DATA_WIDTH +: DATA_WIDTH];
        default: d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(x) + DATA_WIDTH'(y)
                                                + DATA_WIDTH'(f) + DATA_WIDTH'(c);
      endcase
    end
    return d;
  endfunction

  assign start_ok    = enable && (param_width != '0) && (param_height != '0);
  assign width_last  = {1'b0, width_q} - XC'(1);
  assign xblank_last = {1'b0, xblank_q} - XC'(1);
  assign period_last = {1'b0, width_q} + {1'b0, xblank_q} - XC'(1);
  assign height_last = height_q - Y_WIDTH'(1);
  assign yblank_last = yblank_q - Y_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    f_d      = f_q;
    width_d  = width_q;
    height_d = height_q;
    xblank_d = xblank_q;
    yblank_d = yblank_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    valid_d  = valid_q;
    user_d   = user_q;
    last_d   = last_q;
    data_d   = data_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    load     = 1'b0;
    line_end = 1'b0;
    restart  = 1'b0;
    latch    = 1'b0;
    bx       = '0;
    by       = '0;
    bf       = f_q;
    bmode    = mode_q;
    bfill    = fill_q;
    bwidth   = width_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          latch   = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // First cycle after IDLE carries no beat yet; it loads beat (0,0).
        if (!valid_q) begin
          load = 1'b1;
          bx   = x_q[X_WIDTH-1:0];
          by   = y_q;
        end else if (m_axi4s_tready) begin
          if (x_q == width_last) begin
            x_d = '0;
            if (xblank_q != '0) begin
              state_d = ST_HBLANK;
              valid_d = 1'b0;
            end else begin
              line_end = 1'b1;
            end
          end else begin
            x_d  = x_q + XC'(1);
            load = 1'b1;
            bx   = x_q[X_WIDTH-1:0] + X_WIDTH'(1);
            by   = y_q;
          end
        end
      end
      ST_HBLANK: begin
        if (x_q == xblank_last) begin
          x_d      = '0;
          line_end = 1'b1;
        end else begin
          x_d = x_q + XC'(1);
        end
      end
      ST_VBLANK: begin
        if (x_q == period_last) begin
          x_d = '0;
          if (y_q == yblank_last) restart = 1'b1;
          else                    y_d = y_q + Y_WIDTH'(1);
        end else begin
          x_d = x_q + XC'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (line_end) begin
      if (y_q != height_last) begin
        y_d     = y_q + Y_WIDTH'(1);
        state_d = ST_ACTIVE;
        load    = 1'b1;
        bx      = '0;
        by      = y_q + Y_WIDTH'(1);
      end else begin
        f_d = f_q + F_WIDTH'(1);
        if (yblank_q != '0) begin
          state_d = ST_VBLANK;
          x_d     = '0;
          y_d     = '0;
          valid_d = 1'b0;
        end else begin
          restart = 1'b1;
        end
      end
    end

    // Frame boundary without a gap: the next frame's first beat is built from
    // the live params, since they are only being latched on this same edge.
    if (restart) begin
      if (start_ok) begin
        latch   = 1'b1;
        x_d     = '0;
        y_d     = '0;
        state_d = ST_ACTIVE;
        load    = 1'b1;
        bx      = '0;
        by      = '0;
        bf      = f_d;
        bmode   = param_mode;
        bfill   = param_fill;
        bwidth  = param_width;
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    end

    if (latch) begin
      width_d  = param_width;
      height_d = param_height;
      xblank_d = param_x_blank;
      yblank_d = param_y_blank;
      mode_d   = param_mode;
      fill_d   = param_fill;
    end

    if (load) begin
      valid_d = 1'b1;
      data_d  = pattern(bmode, bfill, bx, by, bf);
      user_d  = (bx == '0) && (by == '0);
      last_d  = (bx == bwidth - X_WIDTH'(1));
      tx_d    = bx;
      ty_d    = by;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      f_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
      xblank_q <= '0;
      yblank_q <= '0;
      mode_q   <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      user_q   <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      busy_q   <= 1'b0;
    end else if (cke) begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      f_q      <= f_d;
      width_q  <= width_d;
      height_q <= height_d;
      xblank_q <= xblank_d;
      yblank_q <= yblank_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      user_q   <= user_d;
      last_q   <= last_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      busy_q   <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign m_axi4s_tvalid = valid_q;
  assign m_axi4s_tuser  = user_q;
  assign m_axi4s_tlast  = last_q;
  assign m_axi4s_tdata  = data_q;
  assign m_axi4s_tx     = tx_q;
  assign m_axi4s_ty     = ty_q;
  assign m_axi4s_tf     = f_q;

endmodule

// File: tb/tb_jelly2_axi4s_pattern_generator.sv
// Scoreboard bench for the AXI4-Stream pattern generator (3 components, 2-bit frame counter).
`timescale 1ns/1ps
module tb_jelly2_axi4s_pattern_generator;
  localparam int COMP = 3;
  localparam int DW   = 10;
  localparam int TDW  = COMP * DW;
  localparam int XW   = 16;
  localparam int YW   = 16;
  localparam int FW   = 2;

  typedef struct packed {
    logic [TDW-1:0] d;
    logic           u;
    logic           l;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [FW-1:0]  f;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset, cke, enable, busy, tready;
  logic [XW-1:0]  p_w, p_xb;
  logic [YW-1:0]  p_h, p_yb;
  logic [1:0]     p_mode;
  logic [TDW-1:0] p_fill;
  logic           tuser, tlast, tvalid;
  logic [TDW-1:0] tdata;
  logic [XW-1:0]  tx;
  logic [YW-1:0]  ty;
  logic [FW-1:0]  tf;

  beat_t          sb[$];
  int unsigned    acc_cyc[$];
  int unsigned    user_cyc[$];
  int unsigned    n_checks = 0;
  int unsigned    n_pass = 0;
  int unsigned    cyc = 0;
  int unsigned    model_f = 0;
  logic           bp_en = 1'b0;
  logic [TDW-1:0] pix80, pix88;
  logic           got80, got88;
  logic [66:0]    snap;
  logic           snap_valid = 1'b0;

  jelly2_axi4s_pattern_generator #(
    .COMPONENTS(COMP), .DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW), .F_WIDTH(FW)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke), .enable(enable), .busy(busy),
    .param_width(p_w), .param_height(p_h), .param_x_blank(p_xb), .param_y_blank(p_yb),
    .param_mode(p_mode), .param_fill(p_fill),
    .m_axi4s_tuser(tuser), .m_axi4s_tlast(tlast), .m_axi4s_tdata(tdata),
    .m_axi4s_tx(tx), .m_axi4s_ty(ty), .m_axi4s_tf(tf),
    .m_axi4s_tvalid(tvalid), .m_axi4s_tready(tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [TDW-1:0] model_pix(input int x, input int y, input int f,
                                               input int mode, input logic [TDW-1:0] fill);
    logic [TDW-1:0] r;
    int v;
    r = '0;
    if (mode == 2) return fill;
    for (int c = 0; c < COMP; c++) begin
      if (mode == 1) v = ((((x / 8) + (y / 8)) % 2) == 1) ? 1023 : 0;
      else           v = (x + y + f + c) % 1024;
      r[c*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  task automatic push_frames(input int n, input int w, input int h, input int mode, input logic [TDW-1:0] fill);
    beat_t b;
    for (int fr = 0; fr < n; fr++) begin
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          b.d = model_pix(x, y, int'(model_f), mode, fill);
          b.u = (x == 0 && y == 0);
          b.l = (x == w - 1);
          b.x = XW'(x);
          b.y = YW'(y);
          b.f = FW'(model_f);
          sb.push_back(b);
        end
      end
      model_f = (model_f + 1) % 4;
    end
  endtask

  task automatic set_params(input int w, input int h, input int xb, input int yb, input int mode,
                            input logic [TDW-1:0] fill);
    p_w = XW'(w); p_h = YW'(h); p_xb = XW'(xb); p_yb = YW'(yb); p_mode = 2'(mode); p_fill = fill;
  endtask

  // Drops enable on the negedge where the n-th frame-start beat is handshaken.
  task automatic wait_tusers(input int n, input int limit);
    int seen = 0;
    for (int i = 0; i < limit && seen < n; i++) begin
      @(negedge clk);
      if (tvalid && tuser && tready && cke) begin
        seen++;
        if (seen == n) enable = 1'b0;
      end
    end
    enable = 1'b0;
    check("tuser_wait", seen == n, seen, n);
  endtask

  task automatic wait_idle(input int limit);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (busy && i < limit);
    check("idle_wait", !busy, busy, 0);
  endtask

  task automatic wait_beat(input int x, input int y, input logic need_accept, input logic drop, input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (tvalid && int'(tx) == x && int'(ty) == y && (!need_accept || (tready && cke))) begin
        found = 1'b1;
        if (drop) enable = 1'b0;
      end
    end
    check($sformatf("beat_wait_%0d_%0d", x, y), found, found, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_f = 0;
    sb.delete();
  endtask

  task automatic check_empty(input string name);
    check(name, sb.size() == 0, sb.size(), 0);
  endtask

  initial begin : tready_drv
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    beat_t got, exp;
    forever begin
      @(negedge clk);
      got = {tdata, tuser, tlast, tx, ty, tf};
      if (snap_valid) check("stall_hold", {tvalid, got} == snap, {tvalid, got}, snap);
      snap_valid = tvalid && !(tready && cke) && !reset;
      snap = {tvalid, got};
      if (tvalid && tready && cke && !reset) begin
        acc_cyc.push_back(cyc);
        if (tuser) user_cyc.push_back(cyc);
        if (tx == 8 && ty == 0) begin pix80 = tdata; got80 = 1'b1; end
        if (tx == 8 && ty == 8) begin pix88 = tdata; got88 = 1'b1; end
        if (sb.size() == 0) begin
          check("unexpected_beat", 1'b0, got, '0);
        end else begin
          exp = sb.pop_front();
          check($sformatf("beat_f%0d_x%0d_y%0d", exp.f, exp.x, exp.y), got == exp, got, exp);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [67:0] hold;
    int nb, nv;
    reset = 1'b1; cke = 1'b1; enable = 1'b0;
    set_params(0, 0, 0, 0, 0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid == 1'b0, tvalid, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_tdata", tdata == '0, tdata, 0);
    check("rst_tf", tf == '0, tf, 0);
    check("rst_misc", {tuser, tlast, tx, ty} == '0, {tuser, tlast, tx, ty}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Geometry and ramp: 4x2, x_blank 2, y_blank 1, two frames.
    set_params(4, 2, 2, 1, 0, '0);
    acc_cyc.delete(); user_cyc.delete();
    push_frames(2, 4, 2, 0, '0);
    @(posedge clk); #1 enable = 1'b1;
    wait_tusers(2, 200);
    wait_idle(200);
    check_empty("t1_queue_empty");
    if (acc_cyc.size() == 16 && user_cyc.size() == 2) begin
      check("t1_throughput", acc_cyc[1] - acc_cyc[0] == 1, acc_cyc[1] - acc_cyc[0], 1);
      check("t1_hblank_gap", acc_cyc[4] - acc_cyc[3] == 3, acc_cyc[4] - acc_cyc[3], 3);
      check("t1_vblank_gap", acc_cyc[8] - acc_cyc[7] == 9, acc_cyc[8] - acc_cyc[7], 9);
      check("t1_frame_period", user_cyc[1] - user_cyc[0] == 18, user_cyc[1] - user_cyc[0], 18);
    end else begin
      check("t1_beat_count", 1'b0, acc_cyc.size(), 16);
    end
    check("t1_tf", tf == FW'(model_f), tf, model_f);

    // Backpressure: 8x4 with random tready; params changed mid-frame must not matter.
    bp_en = 1'b1;
    set_params(8, 4, 1, 1, 0, '0);
    push_frames(1, 8, 4, 0, '0);
    @(posedge clk); #1 enable = 1'b1;
    wait_tusers(1, 200);
    set_params(3, 5, 0, 0, 2, '1);
    wait_idle(1000);
    bp_en = 1'b0;
    check_empty("t2_queue_empty");

    // Graceful stop: enable drops at beat 3 of frame 0.
    do_reset();
    set_params(4, 2, 2, 1, 0, '0);
    push_frames(1, 4, 2, 0, '0);
    @(posedge clk); #1 enable = 1'b1;
    wait_beat(3, 0, 1'b1, 1'b1, 100);
    wait_beat(3, 1, 1'b1, 1'b0, 100);
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    check("t3_busy_tail", nb == 8, nb, 8);
    check("t3_tf", tf == FW'(1), tf, 1);
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (tvalid) nv++;
    end
    check("t3_no_valid", nv == 0, nv, 0);
    check_empty("t3_queue_empty");

    // Checker pattern on 16x16.
    got80 = 1'b0; got88 = 1'b0;
    set_params(16, 16, 0, 0, 1, '0);
    push_frames(1, 16, 16, 1, '0);
    @(posedge clk); #1 enable = 1'b1;
    wait_tusers(1, 100);
    wait_idle(600);
    check("t4_checker_8_0", got80 && pix80 == {TDW{1'b1}}, pix80, {TDW{1'b1}});
    check("t4_checker_8_8", got88 && pix88 == '0, pix88, 0);
    check_empty("t4_queue_empty");

    // Solid fill on 16x16.
    acc_cyc.delete();
    set_params(16, 16, 1, 0, 2, {10'h155, 10'h2AA, 10'h3FF});
    push_frames(1, 16, 16, 2, {10'h155, 10'h2AA, 10'h3FF});
    @(posedge clk); #1 enable = 1'b1;
    wait_tusers(1, 100);
    wait_idle(800);
    check("t5_beat_count", acc_cyc.size() == 256, acc_cyc.size(), 256);
    check_empty("t5_queue_empty");

    // cke freeze in mid-frame, then asynchronous reset mid-line.
    set_params(8, 4, 1, 1, 0, '0);
    push_frames(1, 8, 4, 0, '0);
    @(posedge clk); #1 enable = 1'b1;
    wait_beat(3, 0, 1'b0, 1'b0, 100);
    @(posedge clk); #1 cke = 1'b0;
    hold = {tvalid, tdata, tuser, tlast, tx, ty, tf, busy};
    repeat (5) begin
      @(negedge clk);
      check("cke_hold", {tvalid, tdata, tuser, tlast, tx, ty, tf, busy} == hold,
            {tvalid, tdata, tuser, tlast, tx, ty, tf, busy}, hold);
    end
    @(posedge clk); #1 cke = 1'b1;
    wait_beat(2, 1, 1'b0, 1'b0, 200);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_tvalid", tvalid == 1'b0, tvalid, 0);
    check("rst_mid_busy", busy == 1'b0, busy, 0);
    check("rst_mid_outs", {tdata, tuser, tlast, tx, ty, tf} == '0, {tdata, tuser, tlast, tx, ty, tf}, 0);
    sb.delete();
    model_f = 0;
    @(negedge clk); #2 reset = 1'b0;
    push_frames(1, 8, 4, 0, '0);
    wait_tusers(1, 100);
    wait_idle(300);
    check_empty("t6_queue_empty");

    // Frame counter wrap: 1x1 frames back-to-back.
    do_reset();
    acc_cyc.delete();
    set_params(1, 1, 0, 0, 0, '0);
    push_frames(5, 1, 1, 0, '0);
    @(posedge clk); #1 enable = 1'b1;
    wait_tusers(5, 100);
    wait_idle(100);
    check_empty("t7_queue_empty");
    if (acc_cyc.size() == 5)
      check("t7_back_to_back", acc_cyc[4] - acc_cyc[0] == 4, acc_cyc[4] - acc_cyc[0], 4);
    else
      check("t7_beat_count", 1'b0, acc_cyc.size(), 5);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jelly2_axi4s_pattern_generator.md
# jelly2_axi4s_pattern_generator

Synthesizable, parametrised AXI4-Stream video frame source for camera-pipeline bring-up and self-test. It is the next generation of the behavioural AXI4-Stream master model: multi-component pixels, runtime-programmable geometry and blanking, and selectable test patterns, all under full tready backpressure. It sits in place of the CSI-2 receiver output, upstream of the image-processing chain, and produces frames with tuser (frame start) and tlast (line end) marking.

## Interface
- COMPONENTS, 1, pixel components per beat
- DATA_WIDTH, 10, bits per component
- X_WIDTH, 16, width of x counter and width/blank params
- Y_WIDTH, 16, width of y counter and height/blank params
- F_WIDTH, 16, frame counter width
- TDATA_WIDTH, COMPONENTS*DATA_WIDTH, derived; do not override

- reset  in  1  asynchronous, active-high reset
- clk  in  1  the single clock
- cke  in  1  clock enable; 0 freezes all state and outputs
- enable  in  1  run request; sampled at frame boundaries only
- busy  out  1  high while a frame, including its blanking, is in progress
- param_width  in  X_WIDTH  active pixels per line
- param_height  in  Y_WIDTH  active lines per frame
- param_x_blank  in  X_WIDTH  idle cycles after each line
- param_y_blank  in  Y_WIDTH  idle lines after each frame
- param_mode  in  2  0 ramp, 1 checker, 2 solid, 3 ramp
- param_fill  in  TDATA_WIDTH  solid-mode value
- m_axi4s_tuser  out  1  first pixel of frame
- m_axi4s_tlast  out  1  last pixel of line
- m_axi4s_tdata  out  TDATA_WIDTH  pixel; component c at [c*DATA_WIDTH +: DATA_WIDTH]
- m_axi4s_tx / m_axi4s_ty / m_axi4s_tf  out  X_WIDTH / Y_WIDTH / F_WIDTH  coordinates of the current beat
- m_axi4s_tvalid  out  1
- m_axi4s_tready  in  1

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK. Reset enters IDLE. All outputs reset to 0, including tf.
- IDLE: if enable=1 and param_width!=0 and param_height!=0, all params are latched into shadow registers, x and y are cleared, and the state moves to ACTIVE. Param changes have no effect until the next frame start.
- ACTIVE: tvalid=1. A beat is accepted when tvalid & tready & cke.
  - tuser=1 iff x=0 and y=0.
  - tlast=1 iff x=width-1.
  - On accepting a non-last beat: x++.
  - On accepting the tlast beat: x=0. If x_blank!=0, go to HBLANK; otherwise go directly to the next line, or end the line as below.
- HBLANK: tvalid=0 for x_blank cycles. Then:
  - if y<height-1: y++ and return to ACTIVE;
  - else: line is the end of the frame.
- End of frame: tf++ (wraps modulo 2^F_WIDTH). If y_blank!=0, go to VBLANK; otherwise re-evaluate enable as in IDLE in the same cycle, giving back-to-back frames.
- VBLANK: tvalid=0 for y_blank*(width+x_blank) cycles, counted as y_blank lines using the x and y counters. Then re-evaluate enable: start the next frame, or go to IDLE.
- Patterns (x, y, f are the current beat's coordinates; results truncated to DATA_WIDTH):
  - Ramp (modes 0 and 3): component c = x + y + f + c.
  - Checker: all components = all-ones if x[3]^y[3], else 0 (8x8 squares).
  - Solid: tdata = param_fill.
- enable deasserted mid-frame: the frame completes, including its blanking, then the block goes to IDLE. No truncated frames are ever emitted.
- busy = (state != IDLE).

## Timing
- All outputs are registered.
- Enable seen in IDLE at edge n: the first beat (tuser=1, tx=0, ty=0) is valid after edge n+1.
- While tvalid=1 and tready=0, all of tdata, tuser, tlast, tx, ty and tf hold stable.
- The next beat appears the cycle after acceptance. Throughput is 1 beat/cycle with tready=1.
- Frame period with tready=1 and cke=1 is (width+x_blank)*(height+y_blank) cycles.
- cke=0: no state, counter or output change, including blank counters; handshakes are ignored.
- Asynchronous reset mid-frame: outputs return to 0 immediately and the block enters IDLE.

## Test plan
- Geometry and ramp: width=4, height=2, x_blank=2, y_blank=1, mode 0, tready=1, enable held.
  - Frame 0 beats: 0,1,2,3 / 1,2,3,4.
  - tuser on beat 0 only; tlast on beats 3 and 7.
  - 2 idle cycles after each line; the frame-1 tuser beat appears exactly 18 cycles after the frame-0 tuser beat; frame-1 beat 0 = 1.
- Backpressure: random tready at 50% on a 8x4 frame.
  - Outputs are stable while stalled.
  - The received sequence matches the tready=1 run exactly; no beats are lost or duplicated.
- Graceful stop: drop enable at beat 3 of frame 0.
  - All 8 beats are delivered; busy stays 1 through VBLANK and then falls; tf=1.
  - No further tvalid.
- Modes: width=16, height=16, COMPONENTS=3.
  - Checker: pixel (8,0) = 0x3FF on all components, (8,8)=0.
  - Solid with param_fill=0x155_2AA_3FF: every beat equals fill.
- cke and reset: hold cke=0 for 5 cycles mid-line and check that nothing changes.
  - Assert reset mid-line: tvalid falls at once.
  - On release with enable=1: a new frame starts with tuser=1, tf=0.
- Frame counter wrap (F_WIDTH=2), 1x1 frames, no blanking:
  - tf sequence 0,1,2,3,0; ramp beat values 0,1,2,3,0.
